mc_frame_sequencer: RTL and testbench

- Sits directly downstream of axi_slave in the memory controller.
- Consumes the packed axi_frame stream (valid/ready) and turns each frame into array commands: ACTIVATE, PRECHARGE, WRITE, READ.
- Uses an open-page policy: one row is tracked as open, and row timing (tRCD, tRP, tWR) is enforced with down-counters.
- Read data returns from the array straight to axi_slave on array_rdata/array_rvalid and does not pass through this block.

---
 rtl/mc_frame_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_mc_frame_sequencer.sv | 445 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_frame_sequencer.sv
// mc_frame_sequencer: turns the packed axi_frame stream into ACT/PRE/RD/WR
// array commands under an open-page policy with tRCD/tRP/tWR down-counters.
module mc_frame_sequencer #(
    parameter int unsigned AXI_ADDR_WIDTH  = 20,
    parameter int unsigned AXI_DATA_WIDTH  = 64,
    parameter int unsigned AXI_FRAME_WIDTH = AXI_ADDR_WIDTH + AXI_DATA_WIDTH + 3,
    parameter int unsigned ROW_WIDTH       = 14,
    parameter int unsigned COL_WIDTH       = 6,
    parameter int unsigned T_RCD           = 3,
    parameter int unsigned T_RP            = 2,
    parameter int unsigned T_WR            = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       mc_en,
    input  logic [AXI_FRAME_WIDTH-1:0] axi_frame_data,
    input  logic                       axi_frame_valid,
    output logic                       axi_frame_ready,
    output logic                       array_cmd_valid,
    output logic [1:0]                 array_cmd,
    output logic [ROW_WIDTH-1:0]       array_row,
    output logic [COL_WIDTH-1:0]       array_col,
    output logic [AXI_DATA_WIDTH-1:0]  array_wdata,
    output logic                       row_open,
    output logic                       seq_busy
);

    localparam int unsigned RCD_W = $clog2(T_RCD + 2);
    localparam int unsigned RP_W  = $clog2(T_RP + 2);
    localparam int unsigned WR_W  = $clog2(T_WR + 2);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_PRE    = 2'd1;
    localparam logic [1:0] S_ACT    = 2'd2;
    localparam logic [1:0] S_ACCESS = 2'd3;

    localparam logic [1:0] CMD_RD  = 2'd0;
    localparam logic [1:0] CMD_WR  = 2'd1;
    localparam logic [1:0] CMD_ACT = 2'd2;
    localparam logic [1:0] CMD_PRE = 2'd3;

    logic [1:0]                r_state;
    logic                      r_row_open;
    logic [ROW_WIDTH-1:0]      r_open_row;
    logic [RCD_W-1:0]          r_t_rcd;
    logic [RP_W-1:0]           r_t_rp;
    logic [WR_W-1:0]           r_t_wr;
    logic                      r_cmd_valid;
    logic [1:0]                r_cmd;
    logic [ROW_WIDTH-1:0]      r_row;
    logic [COL_WIDTH-1:0]      r_col;
    logic [AXI_DATA_WIDTH-1:0] r_wdata;

    logic [1:0]                w_state_nxt;
    logic                      w_row_open_nxt;
    logic [ROW_WIDTH-1:0]      w_open_row_nxt;
    logic [RCD_W-1:0]          w_t_rcd_nxt;
    logic [RP_W-1:0]           w_t_rp_nxt;
    logic [WR_W-1:0]           w_t_wr_nxt;
    logic                      w_cmd_valid_nxt;
    logic [1:0]                w_cmd_nxt;
    logic [ROW_WIDTH-1:0]      w_row_nxt;
    logic [COL_WIDTH-1:0]      w_col_nxt;
    logic [AXI_DATA_WIDTH-1:0] w_wdata_nxt;

    logic                      w_wr;
    logic                      w_eof;
    logic                      w_unused_sof;
    logic [AXI_ADDR_WIDTH-1:0] w_addr;
    logic [ROW_WIDTH-1:0]      w_row;
    logic [COL_WIDTH-1:0]      w_col;
    logic [AXI_DATA_WIDTH-1:0] w_data;
    logic                      w_row_hit;
    logic                      w_ready;
    logic                      w_fire;

    // Head-frame field extraction; sof carries no control meaning here
    assign w_wr         = axi_frame_data[AXI_FRAME_WIDTH-1];
    assign w_unused_sof = axi_frame_data[AXI_FRAME_WIDTH-2];
    assign w_eof        = axi_frame_data[AXI_FRAME_WIDTH-3];
    assign w_addr       = axi_frame_data[AXI_DATA_WIDTH +: AXI_ADDR_WIDTH];
    assign w_row        = w_addr[AXI_ADDR_WIDTH-1:COL_WIDTH];
    assign w_col        = w_addr[COL_WIDTH-1:0];
    assign w_data       = axi_frame_data[AXI_DATA_WIDTH-1:0];

    // Ready never looks at valid; it is held off while reset is asserted
    assign w_row_hit = r_row_open && (w_row == r_open_row);
    assign w_ready   = (r_state == S_ACCESS) && (r_t_rcd == '0) && mc_en && w_row_hit && !rst;
    assign w_fire    = axi_frame_valid && w_ready;

    assign axi_frame_ready = w_ready;
    assign array_cmd_valid = r_cmd_valid;
    assign array_cmd       = r_cmd;
    assign array_row       = r_row;
    assign array_col       = r_col;
    assign array_wdata     = r_wdata;
    assign row_open        = r_row_open;
    assign seq_busy        = (r_state != S_IDLE) || (r_t_rcd != '0) || (r_t_rp != '0) || (r_t_wr != '0);

    // Next-state, timer and command decision logic
    always_comb begin
        w_state_nxt     = r_state;
        w_row_open_nxt  = r_row_open;
        w_open_row_nxt  = r_open_row;
        w_t_rcd_nxt     = (r_t_rcd != '0) ? (r_t_rcd - RCD_W'(1)) : r_t_rcd;
        w_t_rp_nxt      = (r_t_rp != '0) ? (r_t_rp - RP_W'(1)) : r_t_rp;
        w_t_wr_nxt      = (r_t_wr != '0) ? (r_t_wr - WR_W'(1)) : r_t_wr;
        w_cmd_valid_nxt = 1'b0;
        w_cmd_nxt       = CMD_RD;
        w_row_nxt       = '0;
        w_col_nxt       = '0;
        w_wdata_nxt     = '0;
        case (r_state)
            S_IDLE: begin
                if (axi_frame_valid && mc_en) begin
                    if (w_row_hit) begin
                        w_state_nxt = S_ACCESS;
                    end else if (r_row_open) begin
                        w_state_nxt = S_PRE;
                    end else begin
                        w_state_nxt = S_ACT;
                    end
                end
            end
            S_PRE: begin
                if (r_t_wr == '0) begin
                    w_cmd_valid_nxt = 1'b1;
                    w_cmd_nxt       = CMD_PRE;
                    w_row_nxt       = r_open_row;
                    w_row_open_nxt  = 1'b0;
                    w_t_rp_nxt      = RP_W'(T_RP);
                    w_state_nxt     = S_ACT;
                end
            end
            S_ACT: begin
                if ((r_t_rp == '0) && mc_en && axi_frame_valid) begin
                    w_cmd_valid_nxt = 1'b1;
                    w_cmd_nxt       = CMD_ACT;
                    w_row_nxt       = w_row;
                    w_open_row_nxt  = w_row;
                    w_row_open_nxt  = 1'b1;
                    w_t_rcd_nxt     = RCD_W'(T_RCD);
                    w_state_nxt     = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (w_fire) begin
                    w_cmd_valid_nxt = 1'b1;
                    w_cmd_nxt       = w_wr ? CMD_WR : CMD_RD;
                    w_col_nxt       = w_col;
                    if (w_wr) begin
                        w_wdata_nxt = w_data;
                        w_t_wr_nxt  = WR_W'(T_WR);
                    end
                    if (w_eof) begin
                        w_state_nxt = S_IDLE;
                    end
                end else if (axi_frame_valid && !w_row_hit) begin
                    w_state_nxt = S_PRE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State, timers and registered array command outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_row_open  <= 1'b0;
            r_open_row  <= '0;
            r_t_rcd     <= '0;
            r_t_rp      <= '0;
            r_t_wr      <= '0;
            r_cmd_valid <= 1'b0;
            r_cmd       <= '0;
            r_row       <= '0;
            r_col       <= '0;
            r_wdata     <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_row_open  <= w_row_open_nxt;
            r_open_row  <= w_open_row_nxt;
            r_t_rcd     <= w_t_rcd_nxt;
            r_t_rp      <= w_t_rp_nxt;
            r_t_wr      <= w_t_wr_nxt;
            r_cmd_valid <= w_cmd_valid_nxt;
            r_cmd       <= w_cmd_nxt;
            r_row       <= w_row_nxt;
            r_col       <= w_col_nxt;
            r_wdata     <= w_wdata_nxt;
        end
    end

endmodule

// File: tb/tb_mc_frame_sequencer.sv
// tb_mc_frame_sequencer: table vectors, directed corner sequences and a
// randomized run checked against a transaction-level open-page model.
module tb_mc_frame_sequencer;

    localparam int unsigned AW = 20;
    localparam int unsigned DW = 64;
    localparam int unsigned FW = AW + DW + 3;
    localparam int unsigned RW = 14;
    localparam int unsigned CW = 6;
    localparam int T_RCD = 3;
    localparam int T_RP  = 2;
    localparam int T_WR  = 2;

    localparam logic [1:0] C_RD  = 2'd0;
    localparam logic [1:0] C_WR  = 2'd1;
    localparam logic [1:0] C_ACT = 2'd2;
    localparam logic [1:0] C_PRE = 2'd3;

    logic          clk = 1'b0;
    logic          rst;
    logic          mc_en;
    logic [FW-1:0] axi_frame_data;
    logic          axi_frame_valid;
    logic          axi_frame_ready;
    logic          array_cmd_valid;
    logic [1:0]    array_cmd;
    logic [RW-1:0] array_row;
    logic [CW-1:0] array_col;
    logic [DW-1:0] array_wdata;
    logic          row_open;
    logic          seq_busy;

    always #5 clk = ~clk;

    mc_frame_sequencer dut (
        .clk             (clk),
        .rst             (rst),
        .mc_en           (mc_en),
        .axi_frame_data  (axi_frame_data),
        .axi_frame_valid (axi_frame_valid),
        .axi_frame_ready (axi_frame_ready),
        .array_cmd_valid (array_cmd_valid),
        .array_cmd       (array_cmd),
        .array_row       (array_row),
        .array_col       (array_col),
        .array_wdata     (array_wdata),
        .row_open        (row_open),
        .seq_busy        (seq_busy)
    );

    typedef struct {
        logic          wr;
        logic          sof;
        logic          eof;
        logic [RW-1:0] row;
        logic [CW-1:0] col;
        logic [DW-1:0] data;
    } frame_t;

    typedef struct {
        int            cyc;
        logic [1:0]    cmd;
        logic [RW-1:0] row;
        logic [CW-1:0] col;
        logic [DW-1:0] data;
    } cmd_t;

    typedef struct {
        logic          wr;
        logic [RW-1:0] row;
        logic [CW-1:0] col;
        logic [DW-1:0] data;
        int            exp_pre;
        int            exp_act;
        logic [1:0]    exp_cmd;
    } vec_t;

    frame_t tx_q[$];
    frame_t acc_q[$];
    cmd_t   cmd_log[$];
    int     cyc = 0;
    int     n_acc = 0;
    int     checks = 0;
    int     failures = 0;

    bit            m_open;
    logic [RW-1:0] m_row;
    int            last_wr;
    int            last_pre;
    int            last_act;

    function automatic logic [FW-1:0] pack_frame(input frame_t f);
        return {f.wr, f.sof, f.eof, f.row, f.col, f.data};
    endfunction

    function automatic frame_t unpack_frame(input logic [FW-1:0] d);
        frame_t f;
        f.wr   = d[FW-1];
        f.sof  = d[FW-2];
        f.eof  = d[FW-3];
        f.row  = d[DW+CW +: RW];
        f.col  = d[DW +: CW];
        f.data = d[DW-1:0];
        return f;
    endfunction

    function automatic frame_t mk(input logic wr, input logic eof, input logic [RW-1:0] row,
                                  input logic [CW-1:0] col, input logic [DW-1:0] data);
        frame_t f;
        f.wr   = wr;
        f.sof  = 1'($urandom);
        f.eof  = eof;
        f.row  = row;
        f.col  = col;
        f.data = data;
        return f;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic chk_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            failures++;
            $display("FAIL %s actual=%0d required=[%0d..%0d]", name, act, lo, hi);
        end
    endtask

    // Cycle counter and per-cycle observation of commands and handshakes
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        cmd_t c;
        if (array_cmd_valid) begin
            c.cyc  = cyc;
            c.cmd  = array_cmd;
            c.row  = array_row;
            c.col  = array_col;
            c.data = array_wdata;
            cmd_log.push_back(c);
        end
        if (axi_frame_valid && axi_frame_ready) begin
            acc_q.push_back(unpack_frame(axi_frame_data));
            n_acc++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle(input int n);
        repeat (n) tick();
    endtask

    task automatic clear_model();
        m_open   = 1'b0;
        m_row    = '0;
        last_wr  = -1000;
        last_pre = -1000;
        last_act = -1000;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        axi_frame_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        clear_model();
        cmd_log.delete();
        acc_q.delete();
    endtask

    task automatic chk_zero(input string p);
        chk({p, "_cmd_valid"}, 64'(array_cmd_valid), 0);
        chk({p, "_cmd"}, 64'(array_cmd), 0);
        chk({p, "_row"}, 64'(array_row), 0);
        chk({p, "_col"}, 64'(array_col), 0);
        chk({p, "_wdata"}, array_wdata, 0);
        chk({p, "_ready"}, 64'(axi_frame_ready), 0);
        chk({p, "_row_open"}, 64'(row_open), 0);
        chk({p, "_busy"}, 64'(seq_busy), 0);
    endtask

    // Presents tx_q frames in order, holding each until it is accepted
    task automatic drive_all(input bit gaps, input int max_cyc);
        int n = 0;
        bit hs;
        while (tx_q.size() > 0 && n < max_cyc) begin
            axi_frame_valid = 1'b1;
            axi_frame_data  = pack_frame(tx_q[0]);
            @(negedge clk);
            hs = axi_frame_valid && axi_frame_ready;
            tick();
            n++;
            if (hs && tx_q.size() > 0) begin
                void'(tx_q.pop_front());
                if (gaps && $urandom_range(0, 3) == 0) begin
                    axi_frame_valid = 1'b0;
                    repeat ($urandom_range(1, 3)) tick();
                    n++;
                end
            end
        end
        axi_frame_valid = 1'b0;
        chk("drive_done", 64'(tx_q.size()), 0);
        tx_q.delete();
    endtask

    task automatic wait_acc(input int target, input int max_cyc);
        int n = 0;
        while (n_acc < target && n < max_cyc) begin
            tick();
            n++;
        end
        chk("wait_acc", 64'(n_acc >= target), 1);
    endtask

    // Expected command stream from accepted frames, plus minimum-spacing checks
    task automatic check_stream();
        cmd_t exp[$];
        cmd_t e;
        int   n;
        bit   after_act = 1'b0;
        foreach (acc_q[i]) begin
            if (!m_open || m_row != acc_q[i].row) begin
                if (m_open) begin
                    e = '{0, C_PRE, '0, '0, '0};
                    exp.push_back(e);
                end
                e = '{0, C_ACT, acc_q[i].row, '0, '0};
                exp.push_back(e);
                m_open = 1'b1;
                m_row  = acc_q[i].row;
            end
            e = '{0, acc_q[i].wr ? C_WR : C_RD, '0, acc_q[i].col, acc_q[i].wr ? acc_q[i].data : '0};
            exp.push_back(e);
        end
        chk("stream_len", 64'(cmd_log.size()), 64'(exp.size()));
        n = (cmd_log.size() < exp.size()) ? cmd_log.size() : exp.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("stream%0d_cmd", i), 64'(cmd_log[i].cmd), 64'(exp[i].cmd));
            case (exp[i].cmd)
                C_ACT: begin
                    chk($sformatf("stream%0d_act_row", i), 64'(cmd_log[i].row), 64'(exp[i].row));
                    chk_range("t_rp", cmd_log[i].cyc - last_pre, T_RP, 1 << 30);
                    last_act  = cmd_log[i].cyc;
                    after_act = 1'b1;
                end
                C_PRE: begin
                    chk_range("t_wr", cmd_log[i].cyc - last_wr, T_WR, 1 << 30);
                    last_pre = cmd_log[i].cyc;
                end
                default: begin
                    chk($sformatf("stream%0d_col", i), 64'(cmd_log[i].col), 64'(exp[i].col));
                    if (exp[i].cmd == C_WR) begin
                        chk($sformatf("stream%0d_wdata", i), cmd_log[i].data, exp[i].data);
                        last_wr = cmd_log[i].cyc;
                    end
                    if (after_act) begin
                        chk_range("t_rcd", cmd_log[i].cyc - last_act, T_RCD, 1 << 30);
                        after_act = 1'b0;
                    end
                end
            endcase
        end
        cmd_log.delete();
        acc_q.delete();
    endtask

    vec_t tbl[7];

    initial begin
        int v;
        int base;
        int bad;
        int npre;
        int nact;
        cmd_t acc_c;
        cmd_t act_c;

        tbl[0] = '{1'b1, 14'd100,   6'd50, 64'h1111,             0, 1, C_WR};
        tbl[1] = '{1'b0, 14'd100,   6'd51, 64'h0,                0, 0, C_RD};
        tbl[2] = '{1'b0, 14'd7,     6'd0,  64'h0,                1, 1, C_RD};
        tbl[3] = '{1'b1, 14'd7,     6'd63, 64'hDEAD_BEEF,        0, 0, C_WR};
        tbl[4] = '{1'b1, 14'd16383, 6'd1,  64'hFFFF_FFFF_FFFF_FFFF, 1, 1, C_WR};
        tbl[5] = '{1'b0, 14'd0,     6'd2,  64'h0,                1, 1, C_RD};
        tbl[6] = '{1'b0, 14'd0,     6'd2,  64'h0,                0, 0, C_RD};

        rst = 1'b1;
        mc_en = 1'b1;
        axi_frame_valid = 1'b0;
        axi_frame_data = '0;
        do_reset();
        chk_zero("reset");

        // Single-frame vectors walking the open-page decisions
        for (int i = 0; i < 7; i++) begin
            tx_q.push_back(mk(tbl[i].wr, 1'b1, tbl[i].row, tbl[i].col, tbl[i].data));
            drive_all(1'b0, 100);
            settle(8);
            npre = 0;
            nact = 0;
            acc_c = '{0, 2'd0, '0, '0, '0};
            act_c = '{0, 2'd0, '0, '0, '0};
            foreach (cmd_log[j]) begin
                if (cmd_log[j].cmd == C_PRE) npre++;
                else if (cmd_log[j].cmd == C_ACT) begin nact++; act_c = cmd_log[j]; end
                else acc_c = cmd_log[j];
            end
            chk($sformatf("tv%0d_pre", i), 64'(npre), 64'(tbl[i].exp_pre));
            chk($sformatf("tv%0d_act", i), 64'(nact), 64'(tbl[i].exp_act));
            chk($sformatf("tv%0d_cmd", i), 64'(acc_c.cmd), 64'(tbl[i].exp_cmd));
            chk($sformatf("tv%0d_col", i), 64'(acc_c.col), 64'(tbl[i].col));
            if (tbl[i].wr) chk($sformatf("tv%0d_wdata", i), acc_c.data, tbl[i].data);
            if (tbl[i].exp_act != 0) chk($sformatf("tv%0d_act_row", i), 64'(act_c.row), 64'(tbl[i].row));
            chk($sformatf("tv%0d_row_open", i), 64'(row_open), 1);
            check_stream();
        end

        // Write burst to a closed bank
        do_reset();
        for (int d = 1; d <= 5; d++) tx_q.push_back(mk(1'b1, d == 5, 14'd100, 6'd50, 64'(d)));
        drive_all(1'b0, 100);
        settle(6);
        if (cmd_log.size() == 6) begin
            chk("wb_first_act", 64'(cmd_log[0].cmd), 64'(C_ACT));
            chk_range("wb_trcd", cmd_log[1].cyc - cmd_log[0].cyc, T_RCD, T_RCD + 1);
            for (int k = 1; k < 5; k++) chk("wb_consec", 64'(cmd_log[k+1].cyc - cmd_log[k].cyc), 1);
        end
        chk("wb_row_open", 64'(row_open), 1);
        check_stream();

        // Read burst hitting the open row
        for (int d = 0; d < 5; d++) tx_q.push_back(mk(1'b0, d == 4, 14'd100, 6'(d), 64'h0));
        v = cyc;
        drive_all(1'b0, 100);
        settle(6);
        if (cmd_log.size() == 5) begin
            chk("rh_latency", 64'(cmd_log[0].cyc - v), 2);
            for (int k = 0; k < 4; k++) chk("rh_consec", 64'(cmd_log[k+1].cyc - cmd_log[k].cyc), 1);
        end
        check_stream();

        // Row miss right after a write
        tx_q.push_back(mk(1'b1, 1'b1, 14'd100, 6'd9, 64'hAB));
        tx_q.push_back(mk(1'b0, 1'b1, 14'd7, 6'd4, 64'h0));
        drive_all(1'b0, 100);
        settle(8);
        if (cmd_log.size() == 4) begin
            chk_range("rm_twr", cmd_log[1].cyc - cmd_log[0].cyc, T_WR, T_WR + 1);
            chk_range("rm_trp", cmd_log[2].cyc - cmd_log[1].cyc, T_RP, T_RP + 1);
            chk_range("rm_trcd", cmd_log[3].cyc - cmd_log[2].cyc, T_RCD, T_RCD + 1);
        end
        check_stream();

        // mc_en dropped for 4 cycles after 2 beats
        base = n_acc;
        for (int d = 0; d < 5; d++) tx_q.push_back(mk(1'b1, d == 4, 14'd7, 6'(10 + d), 64'(256 + d)));
        fork
            drive_all(1'b0, 200);
            begin
                wait_acc(base + 2, 50);
                mc_en = 1'b0;
                for (int k = 0; k < 4; k++) begin
                    @(negedge clk);
                    chk("bp_ready_low", 64'(axi_frame_ready), 0);
                    tick();
                end
                mc_en = 1'b1;
            end
        join
        settle(6);
        chk("bp_beats", 64'(n_acc - base), 5);
        check_stream();

        // Reset in the middle of a write burst
        base = n_acc;
        for (int d = 0; d < 5; d++) tx_q.push_back(mk(1'b1, d == 4, 14'd200, 6'(d), 64'(512 + d)));
        fork
            drive_all(1'b0, 200);
            begin
                wait_acc(base + 2, 60);
                rst = 1'b1;
                tx_q.delete();
                tick();
                chk_zero("mid_rst");
                rst = 1'b0;
            end
        join
        check_stream();
        clear_model();
        tx_q.push_back(mk(1'b0, 1'b1, 14'd200, 6'd3, 64'h0));
        drive_all(1'b0, 100);
        settle(8);
        chk("rst_act_first", 64'((cmd_log.size() > 0) ? cmd_log[0].cmd : C_RD), 64'(C_ACT));
        check_stream();

        // Randomized frames, gaps and mc_en toggling against the model
        for (int i = 0; i < 120; i++) begin
            tx_q.push_back(mk(1'($urandom), (i == 119) || ($urandom_range(0, 2) == 0),
                              14'(3 + $urandom_range(0, 2)), 6'($urandom), {$urandom, $urandom}));
        end
        begin
            bit done = 1'b0;
            fork
                begin
                    drive_all(1'b1, 5000);
                    done = 1'b1;
                end
                begin
                    while (!done) begin
                        tick();
                        mc_en = ($urandom_range(0, 4) != 0);
                    end
                    mc_en = 1'b1;
                end
            join
        end
        settle(20);
        check_stream();

        // Idle period with no frames
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (array_cmd_valid) bad++;
            tick();
        end
        chk("idle_cmd", 64'(bad), 0);
        chk("idle_busy", 64'(seq_busy), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
